cpu_mmc1_mapper: RTL and testbench
==================================

Name: cpu_mmc1_mapper

Overview:
- Parametrised CPU address-space mapper for the cartridge side of the NES bus.
- Decodes internal RAM, PPU registers, PRG-RAM and banked PRG-ROM windows.
- Adds MMC1-style serial bank registers, giving switchable PRG/CHR banks and selectable nametable mirroring.
- Sits between the 6502 core and the memories/PPU register file; drives the CHR bank and mirroring controls to the PPU mapper.

Parameters:
PRG_BANKS, 8, number of 16 KB PRG-ROM banks (power of 2, 2..16)
CHR_BANKS, 32, number of 4 KB CHR banks (power of 2, 2..32)
PRG_RAM_AW, 13, PRG-RAM address width (8 KB window)

Ports:
clk  in  1  system clock; all state updates on rising edge
reset_n  in  1  asynchronous, active-low reset
WE  in  1  CPU write strobe (level, may stay high for several cycles)
addr  in  16  CPU address
data_in  in  8  CPU write data
PRG_ROM_out, CPU_RAM_out, PRG_RAM_out, vram_data_out  in  8 each  memory/PPU read data
data_out  out  8  muxed CPU read data
CPU_RAM_WE, PRG_RAM_WE, vram_WE  out  1 each  write enables
CPU_RAM_addr  out  11  addr[10:0]
PRG_RAM_addr  out  PRG_RAM_AW  addr[PRG_RAM_AW-1:0]
PRG_ROM_addr  out  $clog2(PRG_BANKS)+14  {bank, addr[13:0]}
ppu_reg_cs  out  1  active-low PPU register select
ppu_reg_addr  out  3  addr[2:0]
mirror  out  2  0 one-screen lo, 1 one-screen hi, 2 vertical, 3 horizontal
chr_bank0, chr_bank1  out  $clog2(CHR_BANKS) each  CHR bank selects
chr_mode  out  1  0 = 8 KB (chr_bank0 with LSB cleared), 1 = two 4 KB

Behaviour:
- Decode, combinational:
  - 0000-1FFF: CPU RAM; CPU_RAM_WE=WE.
  - 2000-3FFF: ppu_reg_cs=0; vram_WE=WE; data_out=vram_data_out.
  - 6000-7FFF: PRG-RAM; see optional feature.
  - 8000-FFFF: data_out=PRG_ROM_out; writes go to the serial port and never to ROM.
  - Anything else: data_out=0.
  - Every WE output is 0 outside its own window.
- Write detect:
  - we_q holds last-cycle WE.
  - A serial write is accepted only on a cycle where WE=1, we_q=0 and addr[15]=1.
  - A strobe held N cycles counts once. The address and data are sampled on that first cycle.
- Serial port state: shift[4:0], cnt[2:0] (0..4).
  - Accepted write with data_in[7]=1: shift=0, cnt=0, control[3:2]=2'b11. Other registers are unchanged.
  - Otherwise, if cnt<4: shift={data_in[0],shift[4:1]}, cnt++.
  - Otherwise (cnt=4, fifth write): value={data_in[0],shift[4:1]} is committed to the register chosen by addr[14:13]: 0 control, 1 chr0, 2 chr1, 3 prg. Then shift=0, cnt=0.
  - A commit is visible on the outputs the cycle after the accepting edge.
- Registers:
  - control[1:0] drives mirror.
  - control[3:2] is the PRG mode.
  - control[4] drives chr_mode.
  - chr0/chr1 and prg[3:0] are masked to parameter width (modulo bank count).
  - prg[4]=1 disables PRG-RAM.
- PRG bank for addr[14]=0/1, with L = PRG_BANKS-1:
  - mode 0/1: {prg[3:1],0} / {prg[3:1],1}
  - mode 2: 0 / prg
  - mode 3: prg / L
- Reset (asynchronous, any time including mid-sequence):
  - shift=0, cnt=0, we_q=0.
  - control=5'h0C, so mirror=0, mode 3, chr_mode=0.
  - chr0=chr1=0, prg=0.
  - A partial serial sequence is discarded.

Optional Feature:
MMC1_PRG_RAM_EN
- Defined:
  - 6000-7FFF reads PRG_RAM_out when prg[4]=0, else 0.
  - PRG_RAM_WE = WE & ~prg[4] inside that window.
- Undefined:
  - PRG_RAM_WE is tied 0, 6000-7FFF reads return 0, and prg[4] is ignored.
  - PRG_RAM_addr is still driven.

Test Plan:
- Reset, read 0xC123 -> PRG_ROM_addr=0x1C123 (bank 7). Read 0x8123 -> 0x00123 (prg=0). mirror=0, ppu_reg_cs=1.
- Five single-cycle writes to 0xE000, data bit0 = 1,1,0,0,0 -> prg=3 on the next cycle. Read 0x8000 -> PRG_ROM_addr=0x0C000. 0xC000 still maps to 0x1C000.
- Write control value 0x02 via 0x8000, then prg=3 -> mirror=2, mode 0. Read 0x8000 -> 0x08000, read 0xC000 -> 0x0C000.
- Two serial bits written, then a write of 0x80 -> cnt=0 and control[3:2]=3. The next five writes commit cleanly. Repeat with reset_n pulsed mid-sequence instead -> all registers return to reset values.
- WE held high 3 cycles at 0xA000 with bit0=1, repeated five times -> exactly five bits shifted. chr0=0x1F, masked to 5 bits.
- Writes at 0x0005, 0x2007 and 0x6000 (feature on, prg[4]=0) -> only CPU_RAM_WE, vram_WE and PRG_RAM_WE, respectively, assert. Set prg[4]=1 -> a read at 0x6000 returns 0 and PRG_RAM_WE=0.

Source files
------------

// File: rtl/cpu_mmc1_mapper.sv
// rtl/cpu_mmc1_mapper.sv - NES CPU-side address decoder with MMC1-style serial bank registers.
// Optional PRG-RAM window enabled by defining MMC1_PRG_RAM_EN.
module cpu_mmc1_mapper #(
  parameter int PRG_BANKS  = 8,
  parameter int CHR_BANKS  = 32,
  parameter int PRG_RAM_AW = 13,
  localparam int PRG_BW    = $clog2(PRG_BANKS),
  localparam int CHR_BW    = $clog2(CHR_BANKS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  WE,
  input  logic [15:0]           addr,
  input  logic [7:0]            data_in,
  input  logic [7:0]            PRG_ROM_out,
  input  logic [7:0]            CPU_RAM_out,
  input  logic [7:0]            PRG_RAM_out,
  input  logic [7:0]            vram_data_out,
  output logic [7:0]            data_out,
  output logic                  CPU_RAM_WE,
  output logic                  PRG_RAM_WE,
  output logic                  vram_WE,
  output logic [10:0]           CPU_RAM_addr,
  output logic [PRG_RAM_AW-1:0] PRG_RAM_addr,
  output logic [PRG_BW+13:0]    PRG_ROM_addr,
  output logic                  ppu_reg_cs,
  output logic [2:0]            ppu_reg_addr,
  output logic [1:0]            mirror,
  output logic [CHR_BW-1:0]     chr_bank0,
  output logic [CHR_BW-1:0]     chr_bank1,
  output logic                  chr_mode
);

  logic              we_q;
  logic [4:0]        shift_q, shift_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [4:0]        control_q, control_d;
  logic [CHR_BW-1:0] chr0_q, chr0_d, chr1_q, chr1_d;
  logic [PRG_BW-1:0] prg_q, prg_d;
  logic              prg_off_q, prg_off_d;

  logic              accept;
  logic [4:0]        shift_val;
  logic [PRG_BW-1:0] bank;
  logic              in_ram, in_ppu, in_pram, in_rom;
  logic              pram_en;
  logic              unused_ok;

  // Only the rising edge of a held strobe is a serial write.
  assign accept    = WE & ~we_q & addr[15];
  assign shift_val = {data_in[0], shift_q[4:1]};

  always_comb begin
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    control_d = control_q;
    chr0_d    = chr0_q;
    chr1_d    = chr1_q;
    prg_d     = prg_q;
    prg_off_d = prg_off_q;
    if (accept) begin
      if (data_in[7]) begin
        shift_d   = 5'd0;
        cnt_d     = 3'd0;
        control_d = control_q | 5'b01100;
      end else if (cnt_q != 3'd4) begin
        shift_d = shift_val;
        cnt_d   = cnt_q + 3'd1;
      end else begin
        shift_d = 5'd0;
        cnt_d   = 3'd0;
        case (addr[14:13])
          2'd0: control_d = shift_val;
          2'd1: chr0_d    = shift_val[CHR_BW-1:0];
          2'd2: chr1_d    = shift_val[CHR_BW-1:0];
          default: begin
            prg_d     = shift_val[PRG_BW-1:0];
            prg_off_d = shift_val[4];
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q      <= 1'b0;
      shift_q   <= 5'd0;
      cnt_q     <= 3'd0;
      control_q <= 5'h0C;
      chr0_q    <= '0;
      chr1_q    <= '0;
      prg_q     <= '0;
      prg_off_q <= 1'b0;
    end else begin
      we_q      <= WE;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      control_q <= control_d;
      chr0_q    <= chr0_d;
      chr1_q    <= chr1_d;
      prg_q     <= prg_d;
      prg_off_q <= prg_off_d;
    end
  end

  always_comb begin
    bank = prg_q;
    case (control_q[3:2])
      2'd0, 2'd1: bank = (prg_q & ~PRG_BW'(1)) | PRG_BW'(addr[14]);
      2'd2:       bank = addr[14] ? prg_q : '0;
      default:    bank = addr[14] ? PRG_BW'(PRG_BANKS - 1) : prg_q;
    endcase
  end

`ifdef MMC1_PRG_RAM_EN
  assign pram_en   = ~prg_off_q;
  assign unused_ok = ^data_in[6:1];
`else
  assign pram_en   = 1'b0;
  assign unused_ok = ^{data_in[6:1], PRG_RAM_out, prg_off_q};
`endif

  assign in_ram  = (addr[15:13] == 3'b000);
  assign in_ppu  = (addr[15:13] == 3'b001);
  assign in_pram = (addr[15:13] == 3'b011);
  assign in_rom  = addr[15];

  always_comb begin
    data_out = 8'd0;
    if (in_ram)                 data_out = CPU_RAM_out;
    else if (in_ppu)            data_out = vram_data_out;
    else if (in_pram & pram_en) data_out = PRG_RAM_out;
    else if (in_rom)            data_out = PRG_ROM_out;
  end

  assign CPU_RAM_WE   = WE & in_ram;
  assign vram_WE      = WE & in_ppu;
  assign PRG_RAM_WE   = WE & in_pram & pram_en;
  assign CPU_RAM_addr = addr[10:0];
  assign PRG_RAM_addr = addr[PRG_RAM_AW-1:0];
  assign PRG_ROM_addr = {bank, addr[13:0]};
  assign ppu_reg_cs   = ~in_ppu;
  assign ppu_reg_addr = addr[2:0];
  assign mirror       = control_q[1:0];
  assign chr_mode     = control_q[4];
  assign chr_bank0    = chr0_q;
  assign chr_bank1    = chr1_q;

endmodule

// File: tb/tb_cpu_mmc1_mapper.sv
// tb/tb_cpu_mmc1_mapper.sv - scoreboard bench for cpu_mmc1_mapper against a behavioural model.
module tb_cpu_mmc1_mapper;

  localparam int NPRG = 8;
  localparam int NCHR = 32;
`ifdef MMC1_PRG_RAM_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        WE = 1'b0;
  logic [15:0] addr = 16'h0;
  logic [7:0]  data_in = 8'h0;
  logic [7:0]  PRG_ROM_out = 8'h0, CPU_RAM_out = 8'h0, PRG_RAM_out = 8'h0, vram_data_out = 8'h0;
  logic [7:0]  data_out;
  logic        CPU_RAM_WE, PRG_RAM_WE, vram_WE;
  logic [10:0] CPU_RAM_addr;
  logic [12:0] PRG_RAM_addr;
  logic [16:0] PRG_ROM_addr;
  logic        ppu_reg_cs;
  logic [2:0]  ppu_reg_addr;
  logic [1:0]  mirror;
  logic [4:0]  chr_bank0, chr_bank1;
  logic        chr_mode;

  cpu_mmc1_mapper dut (
    .clk(clk), .reset_n(reset_n), .WE(WE), .addr(addr), .data_in(data_in),
    .PRG_ROM_out(PRG_ROM_out), .CPU_RAM_out(CPU_RAM_out), .PRG_RAM_out(PRG_RAM_out),
    .vram_data_out(vram_data_out), .data_out(data_out), .CPU_RAM_WE(CPU_RAM_WE),
    .PRG_RAM_WE(PRG_RAM_WE), .vram_WE(vram_WE), .CPU_RAM_addr(CPU_RAM_addr),
    .PRG_RAM_addr(PRG_RAM_addr), .PRG_ROM_addr(PRG_ROM_addr), .ppu_reg_cs(ppu_reg_cs),
    .ppu_reg_addr(ppu_reg_addr), .mirror(mirror), .chr_bank0(chr_bank0),
    .chr_bank1(chr_bank1), .chr_mode(chr_mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dout, ram_we, pram_we, vram_we, ram_a, pram_a, rom_a, cs, ppu_a, mir, c0, c1, cm;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference state: registers as plain integers, pending serial bits as a queue.
  int m_control, m_chr0, m_chr1, m_prg;
  bit m_weq;
  bit m_bits[$];
  bit cur_rn = 1'b1, cur_we = 1'b0;
  int cur_a = 0, cur_d = 0;

  task automatic model_reset();
    m_control = 12; m_chr0 = 0; m_chr1 = 0; m_prg = 0; m_weq = 0;
    m_bits.delete();
  endtask

  task automatic model_edge();
    int v;
    if (!cur_rn) return;
    if (cur_we && !m_weq && cur_a >= 32768) begin
      if ((cur_d / 128) % 2 == 1) begin
        m_bits.delete();
        m_control = (m_control % 4) + 12 + (m_control / 16) * 16;
      end else if (m_bits.size() < 4) begin
        m_bits.push_back(bit'(cur_d % 2));
      end else begin
        v = (cur_d % 2) * 16;
        for (int i = 0; i < 4; i++) v += int'(m_bits[i]) << i;
        m_bits.delete();
        case ((cur_a / 8192) % 4)
          0: m_control = v;
          1: m_chr0 = v % NCHR;
          2: m_chr1 = v % NCHR;
          default: m_prg = v;
        endcase
      end
    end
    m_weq = cur_we;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    int a = cur_a, mode = (m_control / 4) % 4, p = (m_prg % 16) % NPRG, hi = (a / 16384) % 2, bank;
    bit ram = a < 8192, ppu = a >= 8192 && a < 16384, pram = a >= 24576 && a < 32768, rom = a >= 32768;
    bit pen = FEAT && m_prg < 16;
    if (mode < 2)       bank = ((p / 2) * 2 + hi) % NPRG;
    else if (mode == 2) bank = hi ? p : 0;
    else                bank = hi ? NPRG - 1 : p;
    e.dout = ram ? int'(CPU_RAM_out) : ppu ? int'(vram_data_out) :
             (pram && pen) ? int'(PRG_RAM_out) : rom ? int'(PRG_ROM_out) : 0;
    e.ram_we  = int'(ram && cur_we);
    e.vram_we = int'(ppu && cur_we);
    e.pram_we = int'(pram && pen && cur_we);
    e.ram_a = a % 2048; e.pram_a = a % 8192; e.rom_a = bank * 16384 + a % 16384;
    e.cs = int'(!ppu); e.ppu_a = a % 8; e.mir = m_control % 4; e.cm = (m_control / 16) % 2;
    e.c0 = m_chr0; e.c1 = m_chr1;
    return e;
  endfunction

  task automatic step(input bit rn, input bit we, input int a, input int d);
    @(posedge clk);
    model_edge();
    #1;
    cur_rn = rn; cur_we = we; cur_a = a % 65536; cur_d = d % 256;
    reset_n = rn; WE = we; addr = 16'(cur_a); data_in = 8'(cur_d);
    PRG_ROM_out = 8'($urandom); CPU_RAM_out = 8'($urandom);
    PRG_RAM_out = 8'($urandom); vram_data_out = 8'($urandom);
    if (!rn) model_reset();
    #1;
    sb.push_back(model_out());
  endtask

  task automatic ser(input int a, input int v);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, a, (v >> i) % 2);
      step(1, 0, a, 0);
    end
  endtask

  task automatic chk(input string n, input int got, input int want);
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", n, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_vec++;
      chk("data_out", int'(data_out), e.dout);
      chk("CPU_RAM_WE", int'(CPU_RAM_WE), e.ram_we);
      chk("PRG_RAM_WE", int'(PRG_RAM_WE), e.pram_we);
      chk("vram_WE", int'(vram_WE), e.vram_we);
      chk("CPU_RAM_addr", int'(CPU_RAM_addr), e.ram_a);
      chk("PRG_RAM_addr", int'(PRG_RAM_addr), e.pram_a);
      chk("PRG_ROM_addr", int'(PRG_ROM_addr), e.rom_a);
      chk("ppu_reg_cs", int'(ppu_reg_cs), e.cs);
      chk("ppu_reg_addr", int'(ppu_reg_addr), e.ppu_a);
      chk("mirror", int'(mirror), e.mir);
      chk("chr_bank0", int'(chr_bank0), e.c0);
      chk("chr_bank1", int'(chr_bank1), e.c1);
      chk("chr_mode", int'(chr_mode), e.cm);
    end
  end

  function automatic int rand_addr();
    case ($urandom_range(0, 7))
      0: return $urandom_range(16'h0000, 16'h1FFF);
      1: return $urandom_range(16'h2000, 16'h3FFF);
      2: return $urandom_range(16'h4000, 16'h5FFF);
      3: return $urandom_range(16'h6000, 16'h7FFF);
      default: return $urandom_range(16'h8000, 16'hFFFF);
    endcase
  endfunction

  initial begin
    int a, d, n;
    model_reset();
    #1 reset_n = 1'b0;
    cur_rn = 1'b0;
    step(0, 0, 16'h0000, 0);
    step(1, 0, 16'hC123, 0);
    step(1, 0, 16'h8123, 0);
    ser(16'hE000, 5'b00011);
    step(1, 0, 16'h8000, 0);
    step(1, 0, 16'hC000, 0);
    ser(16'h8000, 5'h02);
    ser(16'hE000, 5'h03);
    step(1, 0, 16'h8000, 0);
    step(1, 0, 16'hC000, 0);
    step(1, 1, 16'hA000, 1); step(1, 0, 16'hA000, 0);
    step(1, 1, 16'hA000, 0); step(1, 0, 16'hA000, 0);
    step(1, 1, 16'h8000, 8'h80); step(1, 0, 16'h8000, 0);
    ser(16'hC000, 5'h15);
    step(1, 1, 16'hA000, 1); step(1, 0, 16'hA000, 0);
    step(1, 1, 16'hE000, 1); step(1, 0, 16'hE000, 0);
    step(0, 0, 16'hE000, 0);
    step(1, 0, 16'hC000, 0);
    ser(16'hA000, 5'h1E);
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < 3; k++) step(1, 1, 16'hA000, 1);
      step(1, 0, 16'hA000, 0);
    end
    step(1, 1, 16'h0005, 8'h55); step(1, 0, 16'h0005, 0);
    step(1, 1, 16'h2007, 8'h55); step(1, 0, 16'h2007, 0);
    step(1, 1, 16'h6000, 8'h55); step(1, 0, 16'h6000, 0);
    ser(16'hE000, 5'h13);
    step(1, 0, 16'h6000, 0);
    step(1, 1, 16'h6000, 8'h55); step(1, 0, 16'h6000, 0);
    for (int it = 0; it < 1500; it++) begin
      a = rand_addr();
      d = $urandom_range(0, 255);
      if ($urandom_range(0, 7) != 0) d = d % 128;
      n = $urandom_range(0, 3);
      if ($urandom_range(0, 199) == 0) step(0, 0, a, d);
      for (int k = 0; k < n; k++) step(1, 1, a, d);
      step(1, 0, a, $urandom_range(0, 255));
    end
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d vectors left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
